// File: rtl/mmio_console_if.sv
// Core data-bus and TX byte-stream signals of the memory-mapped console.
interface mmio_console_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        hit;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    modport master (
        output MemWrite, DataAdr, WriteData, tx_ready,
        input  ReadData, hit, tx_data, tx_valid, irq
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, tx_ready,
        output ReadData, hit, tx_data, tx_valid, irq
    );
endinterface

// File: rtl/mmio_console.sv
// Memory-mapped console: TX byte FIFO drained over valid/ready, plus STATUS,
// CTRL and a free-running CYCLE counter decoded at BASE_ADDR.
module mmio_console #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    mmio_console_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef logic [AW-1:0] ptr_t;

    logic [7:0]    mem [FIFO_DEPTH];
    ptr_t          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, en_q, en_d, irq_en_q, irq_en_d;
    logic [31:0]   cycle_q, cycle_d;

    logic [1:0]  off;
    logic        wr, empty, full, pop, push_req, push_ok;
    logic [31:0] rdata;

    assign bus.hit  = (bus.DataAdr[31:4] == BASE_ADDR[31:4]) && (bus.DataAdr[1:0] == 2'b00);
    assign off      = bus.DataAdr[3:2];
    assign wr       = bus.MemWrite && bus.hit;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign bus.tx_valid = en_q && !empty;
    assign bus.tx_data  = mem[rd_ptr_q];
    assign pop      = bus.tx_valid && bus.tx_ready;

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_req = wr && (off == 2'd0);
    assign push_ok  = push_req && (!full || pop);

    assign bus.irq  = irq_en_q && (empty || ovf_q);

    always_comb begin
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
        wr_ptr_d = wr_ptr_q + ptr_t'(push_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = ovf_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        cycle_d  = cycle_q + 32'd1;
        if (wr && off == 2'd2) begin
            en_d     = bus.WriteData[0];
            irq_en_d = bus.WriteData[1];
            if (bus.WriteData[2]) ovf_d = 1'b0;
        end
        // Dropped byte beats a same-cycle overflow clear.
        if (push_req && !push_ok) ovf_d = 1'b1;
        if (wr && off == 2'd3) cycle_d = bus.WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            cycle_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            cycle_q  <= cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= bus.WriteData[7:0];
    end

    always_comb begin
        rdata = '0;
        if (bus.hit) begin
            unique case (off)
                2'd0: rdata = '0;
                2'd1: rdata = {15'b0, ovf_q, 8'(count_q), 6'b0, empty, full};
                2'd2: rdata = {30'b0, irq_en_q, en_q};
                2'd3: rdata = cycle_q;
                default: rdata = '0;
            endcase
        end
    end
    assign bus.ReadData = rdata;
endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: register reads checked inline, drained
// bytes checked against a queue of expected bytes filled at store time.
module tb_mmio_console;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;
    localparam logic [31:0] A_CY = BASE + 32'hC;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] exp_q[$];

    mmio_console_if bus();

    mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle; a handshake seen at the falling edge retires the queue head.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (rst_n && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL tx_extra: observed byte %h expected no byte", bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", {24'b0, bus.tx_data}, {24'b0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = addr;
        bus.WriteData = data;
        tick();
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
    endtask

    task automatic push(input logic [7:0] b);
        exp_q.push_back(b);
        wr(A_TX, {24'b0, b});
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.MemWrite = 1'b0;
        bus.DataAdr  = addr;
        #1;
        chk(tag, bus.ReadData, exp);
    endtask

    task automatic drain(input int n, input string tag);
        bus.tx_ready = 1'b1;
        repeat (n) tick();
        bus.tx_ready = 1'b0;
        chk({tag, "_valid_off"}, {31'b0, bus.tx_valid}, 32'h0);
        chk({tag, "_all_out"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.MemWrite = 1'b0; bus.DataAdr = 32'h0; bus.WriteData = 32'h0; bus.tx_ready = 1'b0;
        #2;
        chk("rst_valid", {31'b0, bus.tx_valid}, 32'h0);
        chk("rst_irq", {31'b0, bus.irq}, 32'h0);
        rd("rst_status", A_ST, 32'h0000_0002);
        @(posedge clk); #1;
        rd("rst_ctrl", A_CT, 32'h0);
        rd("rst_cycle", A_CY, 32'h0);
        rst_n = 1'b1;

        // Async reset mid-stream
        wr(A_CT, 32'h1);
        push(8'h11);
        push(8'h22);
        chk("pre_valid", {31'b0, bus.tx_valid}, 32'h1);
        chk("pre_head", {24'b0, bus.tx_data}, 32'h11);
        rst_n = 1'b0;
        #1;
        chk("async_valid", {31'b0, bus.tx_valid}, 32'h0);
        rd("async_status", A_ST, 32'h0000_0002);
        rd("async_cycle", A_CY, 32'h0);
        exp_q.delete();
        tick(); tick();
        rd("held_cycle", A_CY, 32'h0);
        rst_n = 1'b1;
        tick();
        rd("cycle_1", A_CY, 32'h1);
        tick();
        rd("cycle_2", A_CY, 32'h2);

        // Ordered drain
        push(8'h41); push(8'h42); push(8'h43);
        chk("q3_valid", {31'b0, bus.tx_valid}, 32'h0);
        rd("q3_status", A_ST, 32'h0000_0300);
        bus.tx_ready = 1'b1;
        wr(A_CT, 32'h1);
        drain(3, "drain3");
        rd("drain3_status", A_ST, 32'h0000_0002);

        // Overflow, sticky flag, irq
        wr(A_CT, 32'h0);
        for (int i = 0; i < 8; i++) push(8'(i));
        wr(A_TX, 32'h99);
        rd("ovf_status", A_ST, 32'h0001_0801);
        wr(A_CT, 32'h2);
        chk("ovf_irq", {31'b0, bus.irq}, 32'h1);
        wr(A_CT, 32'h6);
        chk("clr_irq", {31'b0, bus.irq}, 32'h0);
        rd("clr_status", A_ST, 32'h0000_0801);
        rd("clr_ctrl", A_CT, 32'h0000_0002);
        bus.tx_ready = 1'b1;
        wr(A_CT, 32'h1);
        drain(8, "drain_ovf");

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        rd("full_status", A_ST, 32'h0000_0801);
        bus.tx_ready = 1'b1;
        push(8'hAA);
        bus.tx_ready = 1'b0;
        rd("pushpop_status", A_ST, 32'h0000_0801);
        drain(8, "drain_full");

        // Counter load and wrap
        wr(A_CY, 32'hFFFF_FFFE);
        rd("cyc_load", A_CY, 32'hFFFF_FFFE);
        tick();
        rd("cyc_max", A_CY, 32'hFFFF_FFFF);
        tick();
        rd("cyc_wrap", A_CY, 32'h0000_0000);

        // Decode misses leave all state alone
        wr(A_CT, 32'h2);
        chk("empty_irq", {31'b0, bus.irq}, 32'h1);
        push(8'h55);
        rd("miss_pre_status", A_ST, 32'h0000_0100);
        bus.MemWrite = 1'b1; bus.DataAdr = BASE + 32'h10; bus.WriteData = 32'h77;
        #1;
        chk("miss10_hit", {31'b0, bus.hit}, 32'h0);
        chk("miss10_rdata", bus.ReadData, 32'h0);
        tick();
        bus.MemWrite = 1'b1; bus.DataAdr = BASE + 32'h1; bus.WriteData = 32'h78;
        #1;
        chk("miss1_hit", {31'b0, bus.hit}, 32'h0);
        chk("miss1_rdata", bus.ReadData, 32'h0);
        tick();
        bus.MemWrite = 1'b1; bus.DataAdr = BASE + 32'h9; bus.WriteData = 32'h0;
        tick();
        bus.MemWrite = 1'b0;
        rd("miss_status", A_ST, 32'h0000_0100);
        rd("miss_ctrl", A_CT, 32'h0000_0002);
        bus.tx_ready = 1'b1;
        wr(A_CT, 32'h1);
        drain(2, "drain_miss");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mmio_console.md
Name: mmio_console

Overview:
- Memory-mapped console peripheral on the core's data-memory bus, alongside dmem.
- Decodes core stores and loads at a fixed base address.
- Buffers store bytes in a TX FIFO and drains them over a valid/ready byte stream toward an external sink (UART, sim monitor).
- Also provides a status register, a control register and a free-running cycle counter.
- The top level muxes ReadData from this block or dmem using `hit`.

Parameters:
- BASE_ADDR, 32'hFFFF_0000: 16-byte-aligned base of the register window.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of 2, ≥2, ≤128.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- MemWrite, input, 1: store strobe from core, same cycle as DataAdr/WriteData.
- DataAdr, input, 32: byte address from core.
- WriteData, input, 32: store data from core.
- ReadData, output, 32: load data for DataAdr; combinational, same cycle.
- hit, output, 1: DataAdr lies in the register window (combinational).
- tx_data, output, 8: byte at FIFO head.
- tx_valid, output, 1: tx_data valid.
- tx_ready, input, 1: sink accepts byte this cycle.
- irq, output, 1: interrupt request, level.

Behaviour:
- Decode:
  - hit = (DataAdr[31:4] == BASE_ADDR[31:4]) && (DataAdr[1:0] == 0).
  - Writes act only when MemWrite && hit.
  - ReadData = 0 when hit = 0.
- Register map (offset = DataAdr[3:2]):
  - 0x0 TXDATA: W pushes WriteData[7:0]; R returns 0.
  - 0x4 STATUS: R = {15'b0, overflow, count[7:0] zero-extended, 6'b0, empty, full}. Bit0 full, bit1 empty, bits15:8 count, bit16 overflow. Writes ignored.
  - 0x8 CTRL: RW bits [1:0] = {irq_en, enable}. Writing bit2 = 1 clears overflow; bit2 reads 0. Other bits read 0.
  - 0xC CYCLE: R returns counter. W loads WriteData.
- FIFO:
  - Circular buffer with read/write pointers of clog2(DEPTH) bits, wrapping naturally.
  - Count is clog2(DEPTH)+1 bits.
  - pop = tx_valid && tx_ready.
  - push_req = write to TXDATA.
  - Push is accepted if count < DEPTH, or if pop occurs the same cycle.
  - A rejected push drops the byte and sets sticky overflow.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Pop when empty is impossible, since tx_valid = 0.
- Stream:
  - tx_valid = enable && !empty.
  - tx_data = mem[rd_ptr], valid whenever tx_valid.
  - Handshake completes on any cycle with tx_valid && tx_ready, giving one byte per cycle maximum.
  - If enable clears mid-stream, tx_valid drops next cycle; FIFO contents are retained.
  - A byte written into an empty FIFO appears on tx_valid the following cycle (1-cycle latency).
- Overflow clear vs. new overflow in the same cycle: set wins.
- Cycle counter:
  - 32-bit, increments every cycle and wraps FFFF_FFFF → 0.
  - A CYCLE write loads WriteData; the load wins over increment that cycle, and incrementing resumes the next cycle.
- irq = irq_en && (empty || overflow). Combinational from registered state.
- Reset (reset = 0, asynchronous):
  - Pointers, count, overflow, CTRL and CYCLE all go to 0.
  - Resulting outputs: tx_valid = 0, irq = 0, tx_data = don't care.
  - Reset mid-stream discards FIFO contents; no partial handshake completes.
- FIFO storage itself needs no reset.

Test Plan:
1. Reset: run with enable = 1, 2 bytes queued, tx_ready = 0; pulse reset low between edges → tx_valid = 0 immediately; STATUS reads 0x0000_0002 (empty); CYCLE reads 0 while reset is held, then counts 1, 2, … after release.
2. Ordered drain: enable = 0; store 0x41, 0x42, 0x43 to TXDATA → tx_valid = 0, STATUS = 0x0000_0300. Write CTRL = 1 with tx_ready = 1 → bytes 0x41, 0x42, 0x43 on three consecutive cycles, then tx_valid = 0 and STATUS = 0x0000_0002.
3. Overflow: enable = 0; store 0x00–0x07, then 0x99 → STATUS = 0x0001_0801 and 0x99 is absent when drained. With CTRL irq_en = 1, irq = 1. Write CTRL = 0x6 → overflow clears and irq = 0, because irq_en = 1 but FIFO is full.
4. Full with simultaneous push/pop: FIFO full, enable = 1, tx_ready = 1, store 0xAA the same cycle → push accepted, count stays 8, and 0xAA is the last byte drained.
5. Counter wrap: write CYCLE = 0xFFFF_FFFE → subsequent reads give FFFF_FFFE, FFFF_FFFF, 0000_0000 on successive cycles.
6. Decode miss: store to BASE_ADDR + 0x10 and to BASE_ADDR + 0x1 → hit = 0, ReadData = 0, and no change in STATUS, CTRL or FIFO.
